// File: rtl/tlb.sv
// Fully associative TLB in front of the page-table walker.
// Hits answer in two cycles; misses walk, fill and reply.
module tlb #(
   parameter  int ENTRIES = 8,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic [31:0] req_vaddr,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_paddr,
   output logic        resp_hit,
   output logic        resp_fault,
   input  logic        flush,
   output logic        walk_request,
   output logic [31:0] walk_vaddr,
   input  logic [31:0] walk_paddr,
   input  logic        walk_done,
   input  logic        walk_fault,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_WALK, S_RELEASE, S_RESP
   } state_t;

   state_t state_q, state_d;
   logic [ENTRIES-1:0]        valid_q, valid_d;
   logic [ENTRIES-1:0][19:0]  vpn_q, vpn_d;
   logic [ENTRIES-1:0][19:0]  ppn_q, ppn_d;
   logic [IDX_W-1:0]          victim_q, victim_d;
   logic [31:0]               vaddr_q, vaddr_d;
   logic [31:0]               walk_vaddr_q, walk_vaddr_d;
   logic [31:0]               resp_paddr_q, resp_paddr_d;
   logic                      resp_hit_q, resp_hit_d;
   logic                      resp_fault_q, resp_fault_d;
   logic [15:0]               hit_cnt_q, hit_cnt_d;
   logic [15:0]               miss_cnt_q, miss_cnt_d;

   logic             hit;
   logic [IDX_W-1:0] hit_idx;
   logic             free;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] fill_idx;
   logic             fill_en;
   logic             unused_walk;

   assign unused_walk = ^walk_paddr[11:0];

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      vpn_d        = vpn_q;
      ppn_d        = ppn_q;
      victim_d     = victim_q;
      vaddr_d      = vaddr_q;
      walk_vaddr_d = walk_vaddr_q;
      resp_paddr_d = resp_paddr_q;
      resp_hit_d   = resp_hit_q;
      resp_fault_d = resp_fault_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      fill_en      = 1'b0;
      fill_idx     = victim_q;

      // Scan downward so the lowest matching index ends up selected.
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (valid_q[i] && vpn_q[i] == vaddr_q[31:12]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!valid_q[i]) begin
            free     = 1'b1;
            free_idx = IDX_W'(i);
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               vaddr_d = req_vaddr;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               resp_paddr_d = {ppn_q[hit_idx], vaddr_q[11:0]};
               resp_hit_d   = 1'b1;
               resp_fault_d = 1'b0;
               if (hit_cnt_q != 16'hFFFF)
                  hit_cnt_d = hit_cnt_q + 16'd1;
               state_d = S_RESP;
            end else begin
               walk_vaddr_d = vaddr_q;
               if (miss_cnt_q != 16'hFFFF)
                  miss_cnt_d = miss_cnt_q + 16'd1;
               state_d = S_WALK;
            end
         end
         S_WALK: begin
            if (walk_done) begin
               resp_hit_d = 1'b0;
               if (walk_fault) begin
                  resp_fault_d = 1'b1;
                  resp_paddr_d = '0;
               end else begin
                  resp_fault_d = 1'b0;
                  resp_paddr_d = {walk_paddr[31:12], vaddr_q[11:0]};
                  fill_en      = 1'b1;
               end
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!walk_done)
               state_d = S_RESP;
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (fill_en) begin
         if (free) begin
            fill_idx = free_idx;
         end else begin
            fill_idx = victim_q;
            victim_d = victim_q + IDX_W'(1);
         end
         valid_d[fill_idx] = 1'b1;
         vpn_d[fill_idx]   = vaddr_q[31:12];
         ppn_d[fill_idx]   = walk_paddr[31:12];
      end

      // Flush overrides a same-edge fill.
      if (flush)
         valid_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         valid_q      <= '0;
         vpn_q        <= '0;
         ppn_q        <= '0;
         victim_q     <= '0;
         vaddr_q      <= '0;
         walk_vaddr_q <= '0;
         resp_paddr_q <= '0;
         resp_hit_q   <= 1'b0;
         resp_fault_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         vpn_q        <= vpn_d;
         ppn_q        <= ppn_d;
         victim_q     <= victim_d;
         vaddr_q      <= vaddr_d;
         walk_vaddr_q <= walk_vaddr_d;
         resp_paddr_q <= resp_paddr_d;
         resp_hit_q   <= resp_hit_d;
         resp_fault_q <= resp_fault_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   assign req_ready    = (state_q == S_IDLE);
   assign resp_valid   = (state_q == S_RESP);
   assign walk_request = (state_q == S_WALK);
   assign walk_vaddr   = walk_vaddr_q;
   assign resp_paddr   = resp_paddr_q;
   assign resp_hit     = resp_hit_q;
   assign resp_fault   = resp_fault_q;
   assign hit_count    = hit_cnt_q;
   assign miss_count   = miss_cnt_q;

endmodule
